// File: rtl/capture_sequencer_if.sv
// Sample-RAM ports and UART TX byte stream of the capture sequencer.
// master = sequencer side, slave = RAM / UART side.
interface capture_sequencer_if #(
  parameter int ADDR_W = 14
);
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [7:0]        ram_rdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output ram_we,
    output ram_waddr,
    output ram_wdata,
    output ram_raddr,
    input  ram_rdata,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  ram_we,
    input  ram_waddr,
    input  ram_wdata,
    input  ram_raddr,
    output ram_rdata,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/capture_sequencer.sv
// Logic-analyser acquisition: arm, trigger, capture N samples, stream to UART.
// Define TRIG_TIMEOUT_EN to auto-trigger after TIMEOUT_CYCLES in ARMED.
module capture_sequencer #(
  parameter int ADDR_W = 14,
  parameter int DEPTH1 = 1024,
  parameter int DEPTH2 = 5120,
  parameter int DEPTH3 = 10240
`ifdef TRIG_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 24000000
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                arm,
  input  logic                abort,
  input  logic [1:0]          depth,
  input  logic                adc_en,
  input  logic                adc_clk,
  input  logic [7:0]          adc_data,
  capture_sequencer_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAP,
    S_RD,
    S_TX
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2:0]        adc_sync;
  logic              s_tick;
  logic [ADDR_W-1:0] n_sel;
  logic [ADDR_W-1:0] n_last;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] rd_cnt;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [7:0]        wdata_q;
  logic [7:0]        tx_q;
  logic              tx_first;
  logic              timeout_hit;

  // [1:0] synchronise adc_clk, [2] holds the previous synchronised level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) adc_sync <= '0;
    else          adc_sync <= {adc_sync[1:0], adc_clk};
  end

  assign s_tick = adc_sync[1] & ~adc_sync[2];

  always_comb begin
    n_sel = '0;
    unique case (1'b1)
      (depth == 2'd1): n_sel = ADDR_W'(DEPTH1 - 1);
      (depth == 2'd2): n_sel = ADDR_W'(DEPTH2 - 1);
      (depth == 2'd3): n_sel = ADDR_W'(DEPTH3 - 1);
      default:         n_sel = '0;
    endcase
  end

`ifdef TRIG_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      to_cnt <= '0;
    else if (state_q == S_ARMED && state_d == S_ARMED)
      to_cnt <= to_cnt + TO_W'(1);
    else
      to_cnt <= '0;
  end

  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:
          if (arm && depth != 2'd0) state_d = S_ARMED;
        S_ARMED:
          if (adc_en || timeout_hit) state_d = S_CAP;
        S_CAP:
          if (s_tick && wr_cnt == n_last) state_d = S_RD;
        S_RD:
          state_d = S_TX;
        S_TX:
          if (bus.tx_ready)
            state_d = (rd_cnt == n_last) ? S_IDLE : S_RD;
        default:
          state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy          = (state_q != S_IDLE);
    bus.tx_valid  = (state_q == S_TX);
    // first TX cycle forwards the RAM output; later cycles hold the copy
    bus.tx_data   = tx_first ? bus.ram_rdata : tx_q;
    bus.ram_raddr = rd_cnt;
    bus.ram_we    = we_q;
    bus.ram_waddr = waddr_q;
    bus.ram_wdata = wdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_last   <= '0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      tx_q     <= '0;
      tx_first <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      we_q     <= 1'b0;
      tx_first <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      if (abort) begin
        wr_cnt <= '0;
        rd_cnt <= '0;
      end else begin
        case (state_q)
          S_IDLE:
            if (arm) begin
              if (depth == 2'd0) begin
                err <= 1'b1;
              end else begin
                n_last <= n_sel;
                wr_cnt <= '0;
                rd_cnt <= '0;
              end
            end
          S_CAP:
            if (s_tick) begin
              we_q    <= 1'b1;
              waddr_q <= wr_cnt;
              wdata_q <= adc_data;
              wr_cnt  <= wr_cnt + ADDR_W'(1);
              if (wr_cnt == n_last) rd_cnt <= '0;
            end
          S_RD:
            tx_first <= 1'b1;
          S_TX: begin
            if (tx_first) tx_q <= bus.ram_rdata;
            if (bus.tx_ready) begin
              if (rd_cnt == n_last) done <= 1'b1;
              else                  rd_cnt <= rd_cnt + ADDR_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
